// File: rtl/sipo_deserializer_if.sv
// Serial capture bus for sipo_deserializer: bit stream in, word plus status out.
interface sipo_deserializer_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             sin;
  logic             sin_valid;
  logic             start;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;
  logic             ovr_clr;

  modport master (
    output sin, sin_valid, start, dout_ready, ovr_clr,
    input  dout, dout_valid, busy, bit_cnt, overrun
  );

  modport slave (
    input  sin, sin_valid, start, dout_ready, ovr_clr,
    output dout, dout_valid, busy, bit_cnt, overrun
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel capture: assembles framed bits into WIDTH-bit words on a
// valid/ready output register, with sticky overrun when a word must be dropped.
module sipo_deserializer #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic              clk,
  input  logic              clr_n,
  sipo_deserializer_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    idx, cnt_inc;
  logic [IW-1:0]    pos;
  logic             dv_q, dv_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic             capture, restart, complete;

  // State and output registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: framing, bit placement, completion and output handshake
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dv_d     = dv_q;
    ovr_d    = ovr_q & ~bus.ovr_clr;
    capture  = 1'b0;
    restart  = 1'b0;
    complete = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.sin_valid && bus.start) begin
          capture = 1'b1;
          restart = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.sin_valid) begin
          capture = 1'b1;
          // In continuous mode the last bit of a word always completes it
          restart = bus.start && !(CONTINUOUS && (cnt_q == CW'(WIDTH - 1)));
        end
      end
      default: ;
    endcase

    idx       = restart ? '0 : cnt_q;
    cnt_inc   = idx + CW'(1);
    pos       = LSB_FIRST ? IW'(idx) : (IW'(WIDTH - 1) - IW'(idx));
    word      = restart ? '0 : sh_q;
    word[pos] = bus.sin;

    if (capture) begin
      state_d = SHIFT;
      sh_d    = word;
      cnt_d   = cnt_inc;
      if (cnt_inc == CW'(WIDTH)) begin
        complete = 1'b1;
        sh_d     = '0;
        cnt_d    = '0;
        state_d  = CONTINUOUS ? SHIFT : IDLE;
      end
    end

    // A completed word either loads (slot free or being drained) or is dropped
    if (complete) begin
      if (!dv_q || bus.dout_ready) begin
        dout_d = word;
        dv_d   = 1'b1;
      end else begin
        ovr_d  = 1'b1;
      end
    end else if (dv_q && bus.dout_ready) begin
      dv_d = 1'b0;
    end

    busy_d = (state_d == SHIFT);
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.busy       = busy_q;
  assign bus.bit_cnt    = cnt_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: vector table plus hand-written sequences, with
// scoreboard queues checked whenever a new word appears on dout.
module tb_sipo_deserializer;

  logic clk;
  logic clr_n;

  int errors = 0;
  int checks = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];

  sipo_deserializer_if #(.WIDTH(4)) b0 ();
  sipo_deserializer_if #(.WIDTH(4)) b1 ();
  sipo_deserializer_if #(.WIDTH(4)) b2 ();

  // MSB-first instance mirrors the stimulus of the LSB-first instance
  assign b2.sin        = b0.sin;
  assign b2.sin_valid  = b0.sin_valid;
  assign b2.start      = b0.start;
  assign b2.dout_ready = b0.dout_ready;
  assign b2.ovr_clr    = b0.ovr_clr;

  sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1), .CONTINUOUS(1'b0)) u_dut0 (
    .clk(clk), .clr_n(clr_n), .bus(b0.slave));
  sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1), .CONTINUOUS(1'b1)) u_dut1 (
    .clk(clk), .clr_n(clr_n), .bus(b1.slave));
  sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0), .CONTINUOUS(1'b0)) u_dut2 (
    .clk(clk), .clr_n(clr_n), .bus(b2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [3:0] w, input int gap, input logic st);
    for (int i = 0; i < 4; i++) begin
      b0.sin       = w[i];
      b0.sin_valid = 1'b1;
      b0.start     = st && (i == 0);
      tick();
      b0.sin_valid = 1'b0;
      b0.start     = 1'b0;
      repeat (gap) tick();
    end
  endtask

  // Scoreboard monitors: a new word is a valid dout after idle or after acceptance
  logic dv_last0, rdy_last0, dv_last1, rdy_last1;

  always @(negedge clk) begin
    if (!clr_n) begin
      dv_last0  <= 1'b0;
      rdy_last0 <= 1'b0;
    end else begin
      if (b0.dout_valid && (!dv_last0 || rdy_last0)) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word0: got %0h expected none", b0.dout);
        end else begin
          chk("dout_lsb", 32'(b0.dout), 32'(q0[0]));
          chk("dout_msb", 32'(b2.dout), 32'(rev4(q0[0])));
          void'(q0.pop_front());
        end
      end
      dv_last0  <= b0.dout_valid;
      rdy_last0 <= b0.dout_ready;
    end
  end

  always @(negedge clk) begin
    if (!clr_n) begin
      dv_last1  <= 1'b0;
      rdy_last1 <= 1'b0;
    end else begin
      if (b1.dout_valid && (!dv_last1 || rdy_last1)) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word1: got %0h expected none", b1.dout);
        end else begin
          chk("dout_cont", 32'(b1.dout), 32'(q1[0]));
          void'(q1.pop_front());
        end
      end
      dv_last1  <= b1.dout_valid;
      rdy_last1 <= b1.dout_ready;
    end
  end

  typedef struct {
    logic       sin;
    logic       sv;
    logic       st;
    logic       rdy;
    logic       push;
    logic [3:0] word;
    logic       exp_dv;
    logic       exp_busy;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'd1};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'd2};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'd3};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hD, 1'b1, 1'b0, 3'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0};

    clr_n = 1'b0;
    b0.sin = 1'b0; b0.sin_valid = 1'b0; b0.start = 1'b0; b0.dout_ready = 1'b0; b0.ovr_clr = 1'b0;
    b1.sin = 1'b0; b1.sin_valid = 1'b0; b1.start = 1'b0; b1.dout_ready = 1'b0; b1.ovr_clr = 1'b0;
    tick();
    tick();
    chk("rst_dout", 32'(b0.dout), 32'h0);
    chk("rst_dv", 32'(b0.dout_valid), 32'h0);
    chk("rst_busy", 32'(b0.busy), 32'h0);
    chk("rst_cnt", 32'(b0.bit_cnt), 32'h0);
    chk("rst_ovr", 32'(b0.overrun), 32'h0);
    clr_n = 1'b1;
    tick();

    // Basic word 0xD from the vector table
    for (int i = 0; i < 7; i++) begin
      b0.sin        = tbl[i].sin;
      b0.sin_valid  = tbl[i].sv;
      b0.start      = tbl[i].st;
      b0.dout_ready = tbl[i].rdy;
      if (tbl[i].push) q0.push_back(tbl[i].word);
      tick();
      chk($sformatf("t1_dv[%0d]", i), 32'(b0.dout_valid), 32'(tbl[i].exp_dv));
      chk($sformatf("t1_busy[%0d]", i), 32'(b0.busy), 32'(tbl[i].exp_busy));
      chk($sformatf("t1_cnt[%0d]", i), 32'(b0.bit_cnt), 32'(tbl[i].exp_cnt));
      chk($sformatf("t1_ovr[%0d]", i), 32'(b0.overrun), 32'h0);
    end
    b0.sin_valid = 1'b0;
    tick();

    // PISO loopback of 0xA, LSB shifted out first
    begin
      logic [3:0] piso;
      piso = 4'hA;
      q0.push_back(4'hA);
      for (int i = 0; i < 4; i++) begin
        b0.sin       = piso[0];
        b0.sin_valid = 1'b1;
        b0.start     = (i == 0);
        tick();
        piso = piso >> 1;
      end
      b0.sin_valid = 1'b0;
      b0.start     = 1'b0;
      chk("t2_dv", 32'(b0.dout_valid), 32'h1);
      chk("t2_busy", 32'(b0.busy), 32'h0);
      b0.dout_ready = 1'b1;
      tick();
      b0.dout_ready = 1'b0;
      chk("t2_dv_acc", 32'(b0.dout_valid), 32'h0);
    end

    // Gapped bits 0,1,1,0; word held until ready pulses
    q0.push_back(4'h6);
    for (int i = 0; i < 4; i++) begin
      b0.sin       = i[0] ^ i[1];
      b0.sin_valid = 1'b1;
      b0.start     = (i == 0);
      tick();
      b0.sin_valid = 1'b0;
      b0.start     = 1'b0;
      repeat (2) tick();
      chk($sformatf("t3_cnt[%0d]", i), 32'(b0.bit_cnt), (i == 3) ? 32'h0 : 32'(i + 1));
      chk($sformatf("t3_busy[%0d]", i), 32'(b0.busy), (i == 3) ? 32'h0 : 32'h1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_dv", 32'(b0.dout_valid), 32'h1);
      chk("t3_hold_dout", 32'(b0.dout), 32'h6);
    end
    b0.dout_ready = 1'b1;
    tick();
    b0.dout_ready = 1'b0;
    chk("t3_dv_acc", 32'(b0.dout_valid), 32'h0);

    // Overrun: 0x3 held, 0x5 dropped; clear; set wins over clear
    q0.push_back(4'h3);
    send0(4'h3, 0, 1'b1);
    send0(4'h5, 0, 1'b1);
    chk("t4_ovr", 32'(b0.overrun), 32'h1);
    chk("t4_dout", 32'(b0.dout), 32'h3);
    chk("t4_dv", 32'(b0.dout_valid), 32'h1);
    b0.ovr_clr = 1'b1;
    tick();
    b0.ovr_clr = 1'b0;
    chk("t4_ovr_clr", 32'(b0.overrun), 32'h0);
    chk("t4_dout_kept", 32'(b0.dout), 32'h3);
    b0.ovr_clr = 1'b1;
    send0(4'h9, 0, 1'b1);
    b0.ovr_clr = 1'b0;
    chk("t4_set_wins", 32'(b0.overrun), 32'h1);
    b0.ovr_clr = 1'b1;
    tick();
    b0.ovr_clr = 1'b0;
    chk("t4_ovr_clr2", 32'(b0.overrun), 32'h0);

    // Completion while the held word is being accepted loads with no bubble
    q0.push_back(4'hC);
    for (int i = 0; i < 4; i++) begin
      b0.sin        = (i >= 2);
      b0.sin_valid  = 1'b1;
      b0.start      = (i == 0);
      b0.dout_ready = (i == 3);
      tick();
    end
    b0.sin_valid = 1'b0;
    b0.start     = 1'b0;
    chk("t4_b2b_dv", 32'(b0.dout_valid), 32'h1);
    chk("t4_b2b_dout", 32'(b0.dout), 32'hC);
    chk("t4_b2b_ovr", 32'(b0.overrun), 32'h0);
    tick();
    b0.dout_ready = 1'b0;
    chk("t4_b2b_acc", 32'(b0.dout_valid), 32'h0);

    // Resync: two bits then a fresh start carrying 0x8
    b0.sin = 1'b1; b0.sin_valid = 1'b1; b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    tick();
    b0.sin_valid = 1'b0;
    chk("t5_cnt_partial", 32'(b0.bit_cnt), 32'h2);
    q0.push_back(4'h8);
    send0(4'h8, 0, 1'b1);
    chk("t5_dv", 32'(b0.dout_valid), 32'h1);
    chk("t5_ovr", 32'(b0.overrun), 32'h0);
    b0.dout_ready = 1'b1;
    tick();
    b0.dout_ready = 1'b0;

    // Reset mid-frame with a held word and overrun pending
    q0.push_back(4'h5);
    send0(4'h5, 0, 1'b1);
    send0(4'h7, 0, 1'b1);
    b0.sin = 1'b1; b0.sin_valid = 1'b1; b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    tick();
    b0.sin_valid = 1'b0;
    chk("t5_pre_ovr", 32'(b0.overrun), 32'h1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("t5_rst_dout", 32'(b0.dout), 32'h0);
    chk("t5_rst_dv", 32'(b0.dout_valid), 32'h0);
    chk("t5_rst_busy", 32'(b0.busy), 32'h0);
    chk("t5_rst_cnt", 32'(b0.bit_cnt), 32'h0);
    chk("t5_rst_ovr", 32'(b0.overrun), 32'h0);
    tick();
    clr_n = 1'b1;
    b0.dout_ready = 1'b1;
    repeat (6) tick();
    chk("t5_no_word", 32'(b0.dout_valid), 32'h0);
    b0.dout_ready = 1'b0;

    // Continuous mode: 0x1 then 0xE back to back, start on completion edge ignored
    q1.push_back(4'h1);
    q1.push_back(4'hE);
    b1.dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b1.sin       = (i == 0) || (i >= 5);
      b1.sin_valid = 1'b1;
      b1.start     = (i == 0) || (i == 7);
      tick();
      chk($sformatf("t6_dv[%0d]", i), 32'(b1.dout_valid), ((i == 3) || (i == 7)) ? 32'h1 : 32'h0);
      chk($sformatf("t6_busy[%0d]", i), 32'(b1.busy), 32'h1);
    end
    q1.push_back(4'h3);
    for (int i = 0; i < 4; i++) begin
      b1.sin   = (i < 2);
      b1.start = 1'b0;
      tick();
    end
    b1.sin_valid = 1'b0;
    chk("t6_dv_third", 32'(b1.dout_valid), 32'h1);
    tick();
    chk("t6_dv_drop", 32'(b1.dout_valid), 32'h0);
    chk("t6_ovr", 32'(b1.overrun), 32'h0);
    tick();

    chk("q0_empty", 32'(q0.size()), 32'h0);
    chk("q1_empty", 32'(q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-to-parallel capture stage. It sits directly downstream of the 4-bit PISO shift register and reassembles the LSB-first bit stream into WIDTH-bit words. Completed words are presented on a valid/ready output register. Bit framing and overrun are tracked explicitly so a bench can check PISO→SIPO loopback end to end.

Parameters:
WIDTH, 4, word width in bits; legal range is 2 or more.
LSB_FIRST, 1, 1 = first received bit lands in dout[0] (PISO order); 0 = first bit lands in dout[WIDTH-1].
CONTINUOUS, 0, 1 = go straight to the next word after each WIDTH bits; 0 = return to IDLE and wait for a new start.

Ports:
clk  in  1  sole clock, rising edge.
clr_n  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk (synchronised externally).
sin  in  1  serial data bit (PISO Q).
sin_valid  in  1  sin is a valid bit this cycle.
start  in  1  frame start; only qualified when sin_valid=1.
dout  out  WIDTH  assembled word.
dout_valid  out  1  dout holds an unconsumed word.
dout_ready  in  1  consumer accepts dout at this edge when dout_valid=1.
busy  out  1  a frame is in progress (state SHIFT).
bit_cnt  out  clog2(WIDTH+1)  number of bits captured in the current word.
overrun  out  1  sticky; a completed word was dropped.
ovr_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (clr_n=0, asynchronous): state=IDLE, shift reg=0, dout=0, dout_valid=0, busy=0, bit_cnt=0, overrun=0.
- Reset mid-frame: the partial word and any held dout are discarded. No word is emitted after clr_n rises.
- States:
  - IDLE: sin_valid without start is ignored. sin_valid&start captures sin as bit 0 of a new word, sets bit_cnt=1, goes to SHIFT.
  - SHIFT: each sin_valid captures sin at position bit_cnt and increments bit_cnt. For LSB_FIRST=0 the bit goes to position WIDTH-1-bit_cnt. Cycles with sin_valid=0 hold all state (gaps allowed).
- start in SHIFT (with sin_valid): resynchronise. The partial word is dropped silently, sin becomes bit 0, bit_cnt=1. No overrun is flagged.
- Word completion: the edge that captures bit WIDTH-1 is the completion edge.
  - The word is transferred to dout at that same edge. dout_valid is seen high the cycle after the last bit is sampled (latency 1 from last bit).
  - bit_cnt returns to 0.
  - Next state: SHIFT if CONTINUOUS=1, else IDLE.
  - With CONTINUOUS=1, a start arriving on the completion edge is ignored. The next sin_valid is bit 0 regardless.
- Output handshake:
  - dout_valid stays high and dout stays stable until an edge with dout_ready=1.
  - Acceptance at an edge with no completion: dout_valid goes to 0.
  - Completion at an edge where dout_valid=0, or dout_valid=1 & dout_ready=1: the new word loads and dout_valid=1. Back-to-back words therefore need no bubble.
  - Completion at an edge where dout_valid=1 & dout_ready=0: the new word is dropped, the old dout is retained, and overrun is set to 1.
- overrun is cleared by ovr_clr=1 at a clock edge. If an overrun event and ovr_clr occur at the same edge, set wins.
- busy = (state==SHIFT). In CONTINUOUS mode busy stays 1 after the first start.
- dout_ready while dout_valid=0 has no effect.

Test Plan:
1. WIDTH=4, LSB_FIRST=1: reset, then bits 1,0,1,1 with start on the first bit -> dout=4'b1101 (0xD), dout_valid=1 the cycle after the 4th bit, busy=0 after.
2. PISO loopback: PISO loads D=0xA, its Q drives sin with sin_valid held 4 cycles and start on cycle 1 -> dout=0xA.
3. Gaps: bits 0,1,1,0 with 2 idle cycles between each and dout_ready held 0 -> dout=0x6 held stable until dout_ready pulses, then dout_valid=0.
4. Overrun: with dout_ready=0, words 0x3 then 0x5 -> dout=0x3, overrun=1. Then ovr_clr -> overrun=0 and dout still 0x3.
5. Resync and reset: bits 1,1 then start with bits 0,0,0,1 -> dout=0x8. A separate run asserts clr_n=0 after 2 bits -> all outputs 0 and no word is emitted.
6. CONTINUOUS=1, dout_ready=1: 8 consecutive bits 1,0,0,0,0,1,1,1 -> dout=0x1 then 0xE, each with a single-cycle dout_valid, overrun=0.
